// File: rtl/mult_div_ctrl_pkg.sv
// rtl/mult_div_ctrl_pkg.sv - shared op codes, FSM states and op decode helpers for the MDU
package mult_div_ctrl_pkg;

  localparam int MDU_BITS = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

  // Odd encodings are the unsigned variants.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_ctrl_step.sv
// rtl/mult_div_ctrl_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module mult_div_ctrl_step #(
  parameter int BITS = 32
) (
  input  logic [2*BITS:0]  i_work,
  input  logic [BITS-1:0]  i_operand,
  input  logic             i_is_div,
  output logic [2*BITS:0]  o_work_next,
  output logic             o_qbit
);

  logic [BITS:0]   w_sum;
  logic [BITS:0]   w_rem_sh;
  logic [BITS:0]   w_rem_new;
  logic [BITS+1:0] w_trial;

  always_comb begin
    w_sum     = i_work[0] ? (i_work[2*BITS:BITS] + {1'b0, i_operand}) : i_work[2*BITS:BITS];
    // Remainder stays below the divisor, so the top working bit is always zero here.
    w_rem_sh  = i_work[2*BITS-1:BITS-1];
    w_trial   = {1'b0, w_rem_sh} - {2'b00, i_operand};
    w_rem_new = w_trial[BITS+1] ? w_rem_sh : w_trial[BITS:0];
    if (i_is_div) begin
      o_work_next = {w_rem_new, i_work[BITS-2:0], 1'b0};
      o_qbit      = ~w_trial[BITS+1];
    end else begin
      o_work_next = {1'b0, w_sum, i_work[BITS-1:1]};
      o_qbit      = 1'b0;
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// rtl/mult_div_ctrl.sv - multi-cycle MULT/DIV unit owning HI/LO with start/busy/done handshake
module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
#(
  parameter int BITS = MDU_BITS
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [BITS-1:0] i_rs,
  input  logic [BITS-1:0] i_rt,
  input  logic            i_flush,
  input  logic            i_hi_we,
  input  logic            i_lo_we,
  input  logic [BITS-1:0] i_wdata,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_div_by_zero,
  output logic [BITS-1:0] o_hi,
  output logic [BITS-1:0] o_lo
);

  localparam int CW = $clog2(BITS + 1);
  localparam int WW = 2 * BITS + 1;

  state_t          r_state;
  logic [1:0]      r_op;
  logic [BITS-1:0] r_a;
  logic [BITS-1:0] r_b;
  logic [WW-1:0]   r_work;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_a;
  logic            r_neg_b;
  logic            r_busy;
  logic            r_done;
  logic            r_dbz;
  logic [BITS-1:0] r_hi;
  logic [BITS-1:0] r_lo;

  logic [WW-1:0]     w_work_next;
  logic              w_qbit;
  logic              w_is_div;
  logic              w_signed;
  logic [BITS-1:0]   w_abs_a;
  logic [BITS-1:0]   w_abs_b;
  logic [2*BITS-1:0] w_prod_fix;
  logic [BITS-1:0]   w_quo_fix;
  logic [BITS-1:0]   w_rem_fix;

  mult_div_ctrl_step #(.BITS(BITS)) u_step (
    .i_work      (r_work),
    .i_operand   (r_b),
    .i_is_div    (w_is_div),
    .o_work_next (w_work_next),
    .o_qbit      (w_qbit)
  );

  always_comb begin
    w_is_div   = is_div_op(r_op);
    w_signed   = is_signed_op(r_op);
    w_abs_a    = (w_signed && r_a[BITS-1]) ? -r_a : r_a;
    w_abs_b    = (w_signed && r_b[BITS-1]) ? -r_b : r_b;
    w_prod_fix = (r_neg_a ^ r_neg_b) ? -r_work[2*BITS-1:0] : r_work[2*BITS-1:0];
    w_quo_fix  = (r_neg_a ^ r_neg_b) ? -r_work[BITS-1:0] : r_work[BITS-1:0];
    w_rem_fix  = r_neg_a ? -r_work[2*BITS-1:BITS] : r_work[2*BITS-1:BITS];
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_op    <= MDU_MULT;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      if (!r_busy) begin
        if (i_hi_we) r_hi <= i_wdata;
        if (i_lo_we) r_lo <= i_wdata;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op    <= i_op;
            r_a     <= i_rs;
            r_b     <= i_rt;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          if (i_flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_neg_a <= w_signed & r_a[BITS-1];
            r_neg_b <= w_signed & r_b[BITS-1];
            r_cnt   <= '0;
            if (w_is_div && (r_b == '0)) begin
              // HI keeps the raw dividend so software can inspect it.
              r_hi    <= r_a;
              r_lo    <= '1;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_b     <= w_abs_b;
              r_work  <= {{(BITS+1){1'b0}}, w_abs_a};
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (i_flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_work <= w_work_next | {{(WW-1){1'b0}}, w_qbit};
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == CW'(BITS - 1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (i_flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (w_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*BITS-1:BITS];
              r_lo <= w_prod_fix[BITS-1:0];
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule
